spi_arb2: RTL and testbench

SPI_ARB2 -- requirements
Module: spi_arb2

---
 rtl/spi_arb2.sv | 193 +++++++++++++++++++
 tb/tb_spi_arb2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_arb2.sv
// Two-client arbiter in front of a single 16-bit SPI master, with per-client request buffering and a WAIT timeout.
// Define SPI_ARB_RR_EN for round-robin arbitration on ties; by default client 0 has fixed priority.
module spi_arb2 #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] cmd0,
   output logic        done0,
   output logic [15:0] rd_data0,
   output logic        err0,
   input  logic        req1,
   input  logic [15:0] cmd1,
   output logic        done1,
   output logic [15:0] rd_data1,
   output logic        err1,
   output logic        m_wrt,
   output logic [15:0] m_cmd,
   input  logic        m_done,
   input  logic [15:0] m_rd_data,
   output logic        sel,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  pend_q, pend_d;
   logic [15:0] buf0_q, buf1_q;
   logic [15:0] rd0_q, rd1_q;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic [1:0]  defer_q, defer_d;
   logic        sel_q, sel_d;
   logic        m_wrt_q, m_wrt_d;
   logic [15:0] m_cmd_q, m_cmd_d;
   logic        busy_q, busy_d;
   logic [15:0] cnt_q, cnt_d;
   logic        m_done_prev_q;
   logic [1:0]  req_s, acc_s, drop_s, clr_s, tmo_s;
   logic        rd_ld_s;
   logic        win_s;
`ifdef SPI_ARB_RR_EN
   logic        last_q, last_d;
`endif

   assign req_s  = {req1, req0};
   assign acc_s  = req_s & ~pend_q;
   assign drop_s = req_s & pend_q;

   // Arbitration winner among pending clients
   always_comb begin
`ifdef SPI_ARB_RR_EN
      if (pend_q == 2'b11) begin
         win_s = ~last_q;
      end else begin
         win_s = ~pend_q[0];
      end
`else
      win_s = ~pend_q[0];
`endif
   end

   // Transaction state machine: next state and registered-output next values
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      m_wrt_d = 1'b0;
      m_cmd_d = m_cmd_q;
      cnt_d   = cnt_q;
      clr_s   = 2'b00;
      tmo_s   = 2'b00;
      done_d  = 2'b00;
      rd_ld_s = 1'b0;
`ifdef SPI_ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_LAUNCH;
               sel_d   = win_s;
               m_wrt_d = 1'b1;
               m_cmd_d = win_s ? buf1_q : buf0_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            cnt_d   = 16'd0;
            state_d = S_WAIT;
`ifdef SPI_ARB_RR_EN
            last_d  = sel_q;
`endif
         end
         S_WAIT: begin
            // Only a fresh rise counts; a level left high from a previous transfer is ignored
            if (m_done && !m_done_prev_q) begin
               state_d = S_DONE;
            end else if (cnt_q == (TIMEOUT_CYC - 16'd1)) begin
               tmo_s[sel_q] = 1'b1;
               clr_s[sel_q] = 1'b1;
               state_d      = S_IDLE;
            end else begin
               state_d = S_WAIT;
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         S_DONE: begin
            done_d[sel_q] = 1'b1;
            clr_s[sel_q]  = 1'b1;
            rd_ld_s       = 1'b1;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Request bookkeeping; a drop that collides with the same client's done reports its error a cycle later
   always_comb begin
      pend_d  = (pend_q & ~clr_s) | acc_s;
      err_d   = (drop_s & ~done_d) | defer_q | tmo_s;
      defer_d = drop_s & done_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pend_q        <= 2'b00;
         buf0_q        <= 16'd0;
         buf1_q        <= 16'd0;
         rd0_q         <= 16'd0;
         rd1_q         <= 16'd0;
         done_q        <= 2'b00;
         err_q         <= 2'b00;
         defer_q       <= 2'b00;
         sel_q         <= 1'b0;
         m_wrt_q       <= 1'b0;
         m_cmd_q       <= 16'd0;
         busy_q        <= 1'b0;
         cnt_q         <= 16'd0;
         m_done_prev_q <= 1'b0;
`ifdef SPI_ARB_RR_EN
         last_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         done_q        <= done_d;
         err_q         <= err_d;
         defer_q       <= defer_d;
         sel_q         <= sel_d;
         m_wrt_q       <= m_wrt_d;
         m_cmd_q       <= m_cmd_d;
         busy_q        <= busy_d;
         cnt_q         <= cnt_d;
         m_done_prev_q <= m_done;
`ifdef SPI_ARB_RR_EN
         last_q        <= last_d;
`endif
         if (acc_s[0]) buf0_q <= cmd0;
         if (acc_s[1]) buf1_q <= cmd1;
         if (rd_ld_s && !sel_q) rd0_q <= m_rd_data;
         if (rd_ld_s && sel_q)  rd1_q <= m_rd_data;
      end
   end

   assign done0    = done_q[0];
   assign done1    = done_q[1];
   assign err0     = err_q[0];
   assign err1     = err_q[1];
   assign rd_data0 = rd0_q;
   assign rd_data1 = rd1_q;
   assign m_wrt    = m_wrt_q;
   assign m_cmd    = m_cmd_q;
   assign sel      = sel_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_spi_arb2.sv
// Randomized bench for spi_arb2: a behavioural SPI master drives m_done, and a transaction-level model predicts every output each cycle.
module tb_spi_arb2;

   localparam logic [15:0] TMO = 16'd16;
   localparam int NCYC = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] cmd0, cmd1;
   logic        done0, done1, err0, err1;
   logic [15:0] rd_data0, rd_data1;
   logic        m_wrt;
   logic [15:0] m_cmd;
   logic        m_done;
   logic [15:0] m_rd_data;
   logic        sel, busy;

   int checks = 0;
   int errors = 0;

   spi_arb2 #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .cmd0(cmd0), .done0(done0), .rd_data0(rd_data0), .err0(err0),
      .req1(req1), .cmd1(cmd1), .done1(done1), .rd_data1(rd_data1), .err1(err1),
      .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data),
      .sel(sel), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: timestamps of the current service instead of a state encoding
   bit [1:0]    md_pend;
   logic [15:0] md_buf [2];
   logic [15:0] md_rd  [2];
   bit          md_act;
   bit          md_cli;
   int          md_launch;
   int          md_done_at;
   bit          md_last;
   bit          md_prev;
   bit [1:0]    md_defer;
   // expected outputs for the next cycle
   bit          e_wrt, e_sel, e_busy;
   bit [1:0]    e_done, e_err;
   logic [15:0] e_cmd;

   // SPI master model state
   bit saw_wrt;
   int mst_cnt;

   task automatic model_reset();
      md_pend = 2'b00; md_buf[0] = 16'd0; md_buf[1] = 16'd0;
      md_rd[0] = 16'd0; md_rd[1] = 16'd0;
      md_act = 1'b0; md_cli = 1'b0; md_launch = -10; md_done_at = -10;
      md_last = 1'b0; md_prev = 1'b0; md_defer = 2'b00;
      e_wrt = 1'b0; e_sel = 1'b0; e_busy = 1'b0; e_done = 2'b00; e_err = 2'b00; e_cmd = 16'd0;
   endtask

   task automatic model_step(input int c);
      bit [1:0] clr, acc, n_done, n_err, n_defer, req;
      bit w;
      int wi;
      clr = 2'b00; acc = 2'b00; n_done = 2'b00; n_err = 2'b00; n_defer = 2'b00;
      req = {req1, req0};
      if (md_act) begin
         if (c == md_launch) begin
            // strobe cycle: nothing else happens
         end else if (c == md_done_at) begin
            md_rd[md_cli] = m_rd_data;
            n_done[md_cli] = 1'b1;
            clr[md_cli] = 1'b1;
            md_act = 1'b0;
         end else begin
            wi = c - md_launch - 1;
            if (m_done && !md_prev) begin
               md_done_at = c + 1;
            end else if (wi == int'(TMO) - 1) begin
               n_err[md_cli] = 1'b1;
               clr[md_cli] = 1'b1;
               md_act = 1'b0;
            end
         end
      end else if (md_pend != 2'b00) begin
`ifdef SPI_ARB_RR_EN
         w = (md_pend == 2'b11) ? !md_last : md_pend[1] && !md_pend[0];
`else
         w = md_pend[1] && !md_pend[0];
`endif
         md_last = w;
         md_act = 1'b1;
         md_cli = w;
         md_launch = c + 1;
         md_done_at = -10;
         e_cmd = md_buf[w];
         e_sel = w;
      end
      for (int n = 0; n < 2; n++) begin
         if (req[n]) begin
            if (md_pend[n]) begin
               if (n_done[n]) n_defer[n] = 1'b1;
               else n_err[n] = 1'b1;
            end else begin
               acc[n] = 1'b1;
               md_buf[n] = (n == 0) ? cmd0 : cmd1;
            end
         end
      end
      n_err = n_err | md_defer;
      md_defer = n_defer;
      md_pend = (md_pend & ~clr) | acc;
      md_prev = m_done;
      e_wrt = md_act && (md_launch == c + 1);
      e_busy = md_act;
      e_done = n_done;
      e_err = n_err;
   endtask

   initial begin
      int rst_cnt;
      rst_n = 1'b1;
      req0 = 1'b0; req1 = 1'b0; cmd0 = 16'd0; cmd1 = 16'd0;
      m_done = 1'b0; m_rd_data = 16'd0;
      saw_wrt = 1'b0; mst_cnt = 0;
      model_reset();
      #2 rst_n = 1'b0;
      rst_cnt = 2;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         check("m_wrt", {15'd0, m_wrt}, {15'd0, e_wrt});
         check("m_cmd", m_cmd, e_cmd);
         check("sel", {15'd0, sel}, {15'd0, e_sel});
         check("busy", {15'd0, busy}, {15'd0, e_busy});
         check("done0", {15'd0, done0}, {15'd0, e_done[0]});
         check("done1", {15'd0, done1}, {15'd0, e_done[1]});
         check("err0", {15'd0, err0}, {15'd0, e_err[0]});
         check("err1", {15'd0, err1}, {15'd0, e_err[1]});
         check("rd_data0", rd_data0, md_rd[0]);
         check("rd_data1", rd_data1, md_rd[1]);
         if (rst_cnt == 0 && (c == 1500 || $urandom_range(0, 599) == 0)) rst_cnt = 2;
         if (rst_cnt > 0) begin
            rst_cnt--;
            rst_n = 1'b0;
            req0 = 1'b0; req1 = 1'b0;
            m_done = 1'b0; saw_wrt = 1'b0; mst_cnt = 0;
            model_reset();
         end else begin
            rst_n = 1'b1;
            // master: drop m_done after a strobe, raise it after a random delay (long delays time out)
            if (saw_wrt) begin
               m_done = 1'b0;
               mst_cnt = $urandom_range(1, 22);
            end else if (mst_cnt > 0) begin
               mst_cnt--;
               if (mst_cnt == 0) begin
                  m_done = 1'b1;
                  m_rd_data = 16'($urandom);
               end
            end
            saw_wrt = m_wrt;
            req0 = ($urandom_range(0, 7) == 0);
            req1 = ($urandom_range(0, 7) == 0);
            cmd0 = 16'($urandom);
            cmd1 = 16'($urandom);
            model_step(c);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
